// File: rtl/table_ram_pkg.sv
// Shared types and helpers for the table RAM controller: FSM state encoding,
// even-parity helper and the legal read-latency range.
package table_ram_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_RUN   = 2'd2
    } state_e;

    localparam int unsigned RD_LAT_MIN = 1;
    localparam int unsigned RD_LAT_MAX = 2;

    function automatic logic even_par(input logic [63:0] d);
        return ^d;
    endfunction

    function automatic bit rd_lat_legal(input int unsigned lat);
        return (lat >= RD_LAT_MIN) && (lat <= RD_LAT_MAX);
    endfunction

endpackage

// File: rtl/table_ram_core.sv
// Inferred simple dual-port array: registered read with same-cycle forward
// select, plus an optional output register for two-cycle read latency.
module table_ram_core #(
    parameter int unsigned ADDR_WIDTH = 9,
    parameter int unsigned WORD_WIDTH = 9,
    parameter bit          OUT_REG    = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic [WORD_WIDTH-1:0] i_wdata,
    input  logic                  i_re,
    input  logic [ADDR_WIDTH-1:0] i_raddr,
    input  logic                  i_fwd,
    input  logic [WORD_WIDTH-1:0] i_fwd_data,
    output logic [WORD_WIDTH-1:0] o_rdata
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    logic [WORD_WIDTH-1:0] r_mem [DEPTH];
    logic [WORD_WIDTH-1:0] r_q;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Read register only loads on a read, so the last result is held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
        end else if (i_re) begin
            r_q <= i_fwd ? i_fwd_data : r_mem[i_raddr];
        end
    end

    generate
        if (OUT_REG) begin : g_oreg
            logic                  r_q_load;
            logic [WORD_WIDTH-1:0] r_out;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_q_load <= 1'b0;
                    r_out    <= '0;
                end else begin
                    r_q_load <= i_re;
                    if (r_q_load) begin
                        r_out <= r_q;
                    end
                end
            end

            assign o_rdata = r_out;
        end else begin : g_noreg
            assign o_rdata = r_q;
        end
    endgenerate

endmodule

// File: rtl/table_ram_ctrl.sv
// Parametrised table RAM controller: clear sequencer, write mux, read-during-write
// forwarding and read-valid pipeline. Optional parity: TABLE_RAM_CTRL_PARITY_EN.
module table_ram_ctrl
    import table_ram_pkg::*;
#(
    parameter int unsigned          ADDR_WIDTH   = 9,
    parameter int unsigned          DATA_WIDTH   = 9,
    parameter int unsigned          RD_LATENCY   = 1,
    parameter bit                   BYPASS_EN    = 1'b1,
    parameter bit                   CLEAR_ON_RST = 1'b1,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VAL   = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_clr_req,
    output logic                  o_ready,
    input  logic                  i_wr_en,
    input  logic [ADDR_WIDTH-1:0] i_wr_addr,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic                  i_rd_en,
    input  logic [ADDR_WIDTH-1:0] i_rd_addr,
`ifdef TABLE_RAM_CTRL_PARITY_EN
    input  logic                  i_par_inj,
`endif
    output logic [DATA_WIDTH-1:0] o_rd_data,
    output logic                  o_rd_valid,
    output logic                  o_rd_err
);

    // Illegal latencies fall back to the minimum.
    localparam int unsigned LAT = rd_lat_legal(RD_LATENCY) ? RD_LATENCY : RD_LAT_MIN;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

`ifdef TABLE_RAM_CTRL_PARITY_EN
    localparam int unsigned MEM_W = DATA_WIDTH + 1;
    localparam logic [MEM_W-1:0] CLR_WORD = {even_par(64'(CLEAR_VAL)), CLEAR_VAL};
`else
    localparam int unsigned MEM_W = DATA_WIDTH;
    localparam logic [MEM_W-1:0] CLR_WORD = CLEAR_VAL;
`endif

    state_e                r_state;
    state_e                w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_clr_cnt;
    logic                  r_ready;
    logic                  w_ready_nxt;
    logic                  w_wr_fire;
    logic                  w_rd_fire;
    logic                  w_fwd;
    logic                  w_mem_we;
    logic [ADDR_WIDTH-1:0] w_mem_waddr;
    logic [MEM_W-1:0]      w_mem_wdata;
    logic [MEM_W-1:0]      w_user_word;
    logic [MEM_W-1:0]      w_core_q;
    logic [LAT-1:0]        r_vld;

    assign w_wr_fire = r_ready & i_wr_en;
    assign w_rd_fire = r_ready & i_rd_en;
    assign w_fwd     = BYPASS_EN && w_wr_fire && (i_wr_addr == i_rd_addr);

`ifdef TABLE_RAM_CTRL_PARITY_EN
    assign w_user_word = {even_par(64'(i_wr_data)) ^ i_par_inj, i_wr_data};
`else
    assign w_user_word = i_wr_data;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  w_state_nxt = CLEAR_ON_RST ? ST_CLEAR : ST_RUN;
            ST_CLEAR: if (r_clr_cnt == LAST_ADDR) w_state_nxt = ST_RUN;
            ST_RUN:   if (i_clr_req) w_state_nxt = ST_CLEAR;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Clear writes take priority; user writes only reach the array in RUN.
    always_comb begin
        w_mem_we    = 1'b0;
        w_mem_waddr = i_wr_addr;
        w_mem_wdata = w_user_word;
        case (r_state)
            ST_CLEAR: begin
                w_mem_we    = 1'b1;
                w_mem_waddr = r_clr_cnt;
                w_mem_wdata = CLR_WORD;
            end
            ST_RUN:   w_mem_we = w_wr_fire;
            default:  w_mem_we = 1'b0;
        endcase
        w_ready_nxt = (w_state_nxt == ST_RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ready   <= 1'b0;
            r_clr_cnt <= '0;
        end else begin
            r_ready <= w_ready_nxt;
            if (r_state == ST_CLEAR) begin
                r_clr_cnt <= r_clr_cnt + ADDR_WIDTH'(1);
            end else begin
                r_clr_cnt <= '0;
            end
        end
    end

    // Valid pipeline runs independently of the FSM so in-flight reads finish.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld <= '0;
        end else begin
            r_vld[0] <= w_rd_fire;
            for (int i = 1; i < int'(LAT); i++) begin
                r_vld[i] <= r_vld[i-1];
            end
        end
    end

    table_ram_core #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .WORD_WIDTH (MEM_W),
        .OUT_REG    (LAT == RD_LAT_MAX)
    ) u_core (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_we       (w_mem_we),
        .i_waddr    (w_mem_waddr),
        .i_wdata    (w_mem_wdata),
        .i_re       (w_rd_fire),
        .i_raddr    (i_rd_addr),
        .i_fwd      (w_fwd),
        .i_fwd_data (w_user_word),
        .o_rdata    (w_core_q)
    );

    assign o_ready    = r_ready;
    assign o_rd_valid = r_vld[LAT-1];
    assign o_rd_data  = w_core_q[DATA_WIDTH-1:0];

`ifdef TABLE_RAM_CTRL_PARITY_EN
    assign o_rd_err = o_rd_valid & (even_par(64'(w_core_q[DATA_WIDTH-1:0])) ^ w_core_q[DATA_WIDTH]);
`else
    assign o_rd_err = 1'b0;
`endif

endmodule

// File: tb/tb_table_ram_ctrl.sv
// Bench for table_ram_ctrl: two instances (latency 1 / bypass on / clear 0 and
// latency 2 / bypass off / clear 3) driven in lockstep against a behavioural model.
`timescale 1ns/1ps
module tb_table_ram_ctrl;

    localparam int DEPTH = 512;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clr_req = 1'b0;
    logic       wr_en = 1'b0;
    logic       rd_en = 1'b0;
    logic       par_inj = 1'b0;
    logic [8:0] wr_addr = '0;
    logic [8:0] wr_data = '0;
    logic [8:0] rd_addr = '0;

    logic       ready_a, vld_a, err_a;
    logic       ready_b, vld_b, err_b;
    logic [8:0] data_a, data_b;

    int checks = 0;
    int errors = 0;
    int vcnt_a = 0;
    int vcnt_b = 0;

    always #5 clk = ~clk;

    table_ram_ctrl #(
        .ADDR_WIDTH(9), .DATA_WIDTH(9), .RD_LATENCY(1), .BYPASS_EN(1'b1),
        .CLEAR_ON_RST(1'b1), .CLEAR_VAL(9'h000)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .i_clr_req(clr_req), .o_ready(ready_a),
        .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
        .i_rd_en(rd_en), .i_rd_addr(rd_addr),
`ifdef TABLE_RAM_CTRL_PARITY_EN
        .i_par_inj(par_inj),
`endif
        .o_rd_data(data_a), .o_rd_valid(vld_a), .o_rd_err(err_a)
    );

    table_ram_ctrl #(
        .ADDR_WIDTH(9), .DATA_WIDTH(9), .RD_LATENCY(2), .BYPASS_EN(1'b0),
        .CLEAR_ON_RST(1'b1), .CLEAR_VAL(9'h003)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .i_clr_req(clr_req), .o_ready(ready_b),
        .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
        .i_rd_en(rd_en), .i_rd_addr(rd_addr),
`ifdef TABLE_RAM_CTRL_PARITY_EN
        .i_par_inj(par_inj),
`endif
        .o_rd_data(data_b), .o_rd_valid(vld_b), .o_rd_err(err_b)
    );

    function automatic int lat_of(input int i);
        return i + 1;
    endfunction

    function automatic bit byp_of(input int i);
        return i == 0;
    endfunction

    function automatic logic [8:0] cv_of(input int i);
        return (i == 0) ? 9'h000 : 9'h003;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        int         iss;
        logic [8:0] d0;
        logic [8:0] d1;
        bit         b0;
        bit         b1;
    } rd_t;

    logic [8:0] m_mem [2][DEPTH];
    bit         m_bad [2][DEPTH];
    rd_t        m_rd[$];
    int         m_head [2] = '{0, 0};
    bit         m_run = 1'b0;
    bit         m_clr = 1'b0;
    bit         m_start = 1'b1;
    int         m_pos = 0;
    int         cyc = 0;
    bit         m_vld [2] = '{1'b0, 1'b0};
    logic [8:0] m_dat [2] = '{9'h0, 9'h0};
    bit         m_err [2] = '{1'b0, 1'b0};

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_run = 1'b0; m_clr = 1'b0; m_start = 1'b1; m_pos = 0;
            m_rd.delete();
            for (int i = 0; i < 2; i++) begin
                m_head[i] = 0; m_vld[i] = 1'b0; m_dat[i] = '0; m_err[i] = 1'b0;
            end
        end else begin
            rd_t e;
            cyc++;
            if (m_run && rd_en) begin
                e.iss = cyc;
                for (int i = 0; i < 2; i++) begin
                    logic [8:0] d;
                    bit         b;
                    if (byp_of(i) && wr_en && wr_addr == rd_addr) begin
                        d = wr_data; b = par_inj;
                    end else begin
                        d = m_mem[i][rd_addr]; b = m_bad[i][rd_addr];
                    end
                    if (i == 0) begin e.d0 = d; e.b0 = b; end
                    else begin e.d1 = d; e.b1 = b; end
                end
                m_rd.push_back(e);
            end
            if (m_run && wr_en) begin
                for (int i = 0; i < 2; i++) begin
                    m_mem[i][wr_addr] = wr_data; m_bad[i][wr_addr] = par_inj;
                end
            end
            if (m_start) begin
                m_start = 1'b0; m_clr = 1'b1; m_pos = 0;
            end else if (m_clr) begin
                for (int i = 0; i < 2; i++) begin
                    m_mem[i][m_pos] = cv_of(i); m_bad[i][m_pos] = 1'b0;
                end
                m_pos++;
                if (m_pos == DEPTH) begin m_clr = 1'b0; m_run = 1'b1; end
            end else if (m_run && clr_req) begin
                m_run = 1'b0; m_clr = 1'b1; m_pos = 0;
            end
            for (int i = 0; i < 2; i++) begin
                m_vld[i] = 1'b0;
                if (m_head[i] < m_rd.size() && m_rd[m_head[i]].iss + lat_of(i) - 1 == cyc) begin
                    m_vld[i] = 1'b1;
                    m_dat[i] = (i == 0) ? m_rd[m_head[i]].d0 : m_rd[m_head[i]].d1;
                    m_err[i] = (i == 0) ? m_rd[m_head[i]].b0 : m_rd[m_head[i]].b1;
                    m_head[i]++;
                end
            end
        end
    end

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        chk("ready_a", 32'(ready_a), 32'(m_run));
        chk("ready_b", 32'(ready_b), 32'(m_run));
        chk("valid_a", 32'(vld_a), 32'(m_vld[0]));
        chk("valid_b", 32'(vld_b), 32'(m_vld[1]));
        chk("data_a", 32'(data_a), 32'(m_dat[0]));
        chk("data_b", 32'(data_b), 32'(m_dat[1]));
        chk("err_a", 32'(err_a), 32'(m_err[0]));
        chk("err_b", 32'(err_b), 32'(m_err[1]));
    end

    always @(negedge clk) begin
        if (vld_a) vcnt_a++;
        if (vld_b) vcnt_b++;
    end

    // ---------------- stimulus ----------------
    task automatic drive(input bit we, input int wa, input int wd,
                         input bit re, input int ra, input bit cr);
        wr_en = we; wr_addr = 9'(wa); wr_data = 9'(wd);
        rd_en = re; rd_addr = 9'(ra); clr_req = cr;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 0, 0, 1'b0, 0, 1'b0);
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!ready_a && n < 2000) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        int n;
        int z;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;

        // Power-up clear: IDLE cycle plus 512 clear cycles.
        wait_ready(n);
        chk("t1_clear_len", 32'(n), 32'd513);
        vcnt_a = 0; vcnt_b = 0;
        for (int a = 0; a < DEPTH; a++) drive(1'b0, 0, 0, 1'b1, a, 1'b0);
        idle(3);
        chk("t1_pulses_a", 32'(vcnt_a), 32'd512);
        chk("t1_pulses_b", 32'(vcnt_b), 32'd512);
        chk("t1_last_a", 32'(data_a), 32'h000);
        chk("t1_last_b", 32'(data_b), 32'h003);

        // Pattern write then back-to-back read.
        for (int a = 0; a < DEPTH; a++) drive(1'b1, a, 'h1FF - a, 1'b0, 0, 1'b0);
        vcnt_a = 0; vcnt_b = 0;
        for (int a = 0; a < DEPTH; a++) begin
            drive(1'b0, 0, 0, 1'b1, a, 1'b0);
            if (a == 0) begin
                chk("t2_first_vld_a", 32'(vld_a), 32'd1);
                chk("t2_first_a", 32'(data_a), 32'h1FF);
            end
            if (a == 1) chk("t2_first_b", 32'(data_b), 32'h1FF);
        end
        idle(3);
        chk("t2_pulses_a", 32'(vcnt_a), 32'd512);
        chk("t2_pulses_b", 32'(vcnt_b), 32'd512);

        // Read-during-write, same and different address.
        drive(1'b1, 5, 'h155, 1'b0, 0, 1'b0);
        drive(1'b1, 5, 'h0AA, 1'b1, 5, 1'b0);
        chk("t3_byp_vld_a", 32'(vld_a), 32'd1);
        chk("t3_byp_a", 32'(data_a), 32'h0AA);
        idle(1);
        chk("t3_old_vld_b", 32'(vld_b), 32'd1);
        chk("t3_old_b", 32'(data_b), 32'h155);
        drive(1'b1, 6, 'h011, 1'b1, 8, 1'b0);
        chk("t3_diff_a", 32'(data_a), 32'h1F7);
        idle(1);
        chk("t3_diff_b", 32'(data_b), 32'h1F7);
        idle(2);

        // Clear request with a read of address 7 in flight.
        drive(1'b0, 0, 0, 1'b1, 7, 1'b1);
        chk("t4_ready_drop", 32'(ready_a), 32'd0);
        chk("t4_inflight_a", 32'(data_a), 32'h1F8);
        z = 0;
        while (!ready_a && z < 2000) begin
            z++;
            drive(1'b1, 7, 'h055, 1'b1, 7, 1'b0);
            if (z == 1) begin
                chk("t4_inflight_vld_b", 32'(vld_b), 32'd1);
                chk("t4_inflight_b", 32'(data_b), 32'h1F8);
            end
        end
        chk("t4_busy_len", 32'(z), 32'd512);
        drive(1'b0, 0, 0, 1'b1, 7, 1'b0);
        chk("t4_after_a", 32'(data_a), 32'h000);
        idle(1);
        chk("t4_after_b", 32'(data_b), 32'h003);
        idle(2);

        // Reset mid-clear at count 100; write+clear in the same cycle.
        drive(1'b1, 300, 'h123, 1'b0, 0, 1'b1);
        idle(100);
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        wait_ready(n);
        chk("t5_restart_len", 32'(n), 32'd513);
        drive(1'b0, 0, 0, 1'b1, 300, 1'b0);
        chk("t5_addr300_a", 32'(data_a), 32'h000);
        idle(1);
        chk("t5_addr300_b", 32'(data_b), 32'h003);
        drive(1'b0, 0, 0, 1'b1, 511, 1'b0);
        idle(3);

`ifdef TABLE_RAM_CTRL_PARITY_EN
        // Parity injection on address 9; address 10 stays clean.
        par_inj = 1'b1;
        drive(1'b1, 9, 'h0F0, 1'b0, 0, 1'b0);
        par_inj = 1'b0;
        drive(1'b0, 0, 0, 1'b1, 9, 1'b0);
        chk("t6_err_a", 32'(err_a), 32'd1);
        idle(1);
        chk("t6_err_b", 32'(err_b), 32'd1);
        drive(1'b0, 0, 0, 1'b1, 10, 1'b0);
        chk("t6_clean_a", 32'(err_a), 32'd0);
        idle(1);
        chk("t6_clean_b", 32'(err_b), 32'd0);
        idle(2);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog expired at %0t", $time);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
